blockram_access_ctrl: RTL
=========================

BLOCKRAM_ACCESS_CTRL -- requirements
Module: blockram_access_ctrl

Interface
REQ-001 SHALL have parameter SINGLE_ENTRY_SIZE_IN_BITS, default 64, entry width W.
REQ-002 SHALL have parameter NUMBER_SET, default 64, number of RAM sets.
REQ-003 SHALL have parameter SET_PTR_WIDTH_IN_BITS, default 6, set address width A.
REQ-004 SHALL have ports: clk_in  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: reset_n_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: read_req_valid_in  input  1; read_req_addr_in  input  A; read_req_ready_out  output  1.
REQ-007 SHALL have ports: write_req_valid_in  input  1; write_req_addr_in  input  A; write_req_data_in  input  W; write_req_ready_out  output  1.
REQ-008 SHALL have ports: read_resp_valid_out  output  1; read_resp_data_out  output  W; read_resp_ready_in  input  1.
REQ-009 SHALL have ports: evict_valid_out  output  1; evict_data_out  output  W; evict_ready_in  input  1.
REQ-010 SHALL have RAM-side ports: ram_read_en_out  output  1; ram_read_set_addr_out  output  A; ram_read_entry_in  input  W.
REQ-011 SHALL have RAM-side ports: ram_write_en_out  output  1; ram_write_set_addr_out  output  A; ram_write_entry_out  output  W; ram_evict_entry_in  input  W.

Function
REQ-012 SHALL transfer on any valid/ready pair when both are high at a rising edge; valid/ready handshake on all four channels.
REQ-013 SHALL keep two 2-entry FIFOs: read-response FIFO and evict FIFO; each tracks credits = occupancy + in-flight (0..2).
REQ-014 SHALL drive read_req_ready_out = 1 iff read credits < 2 (combinational from state only, not from valid).
REQ-015 SHALL drive write_req_ready_out = 1 iff evict credits < 2.
REQ-016 SHALL issue read when read handshake occurs: ram_read_en_out=1, ram_read_set_addr_out=read_req_addr_in, same cycle (combinational pass-through).
REQ-017 SHALL issue write when write handshake occurs: ram_write_en_out=1, ram_write_set_addr_out=write_req_addr_in, ram_write_entry_out=write_req_data_in, and ram_read_en_out forced 1 (RAM gates writes on read enable).
REQ-018 SHALL, on write-only issue, drive ram_read_set_addr_out=write_req_addr_in and discard the resulting read data.
REQ-019 SHALL allow read and write to issue in the same cycle, independently.
REQ-020 SHALL capture ram_read_entry_in into read-response FIFO exactly one cycle after a read issue (latency: issue edge N, data in FIFO after edge N+1, read_resp_valid_out high in cycle N+1).
REQ-021 SHALL capture ram_evict_entry_in into evict FIFO one cycle after each write issue, same timing as REQ-020.
REQ-022 SHALL return pre-write data when read and write target same address in same cycle; read issued the cycle after a write SHALL return new data.
REQ-023 SHALL present FIFOs in order, head on *_data_out; data held stable while valid high and ready low.
REQ-024 SHALL update credits: +1 on issue, -1 on output handshake; simultaneous issue and drain leaves count unchanged; count never exceeds 2 nor underflows.
REQ-025 SHALL sustain one read and one write per cycle when response ready inputs are held high.
REQ-026 SHALL drive ram_*_en_out low and address/data outputs 0 in cycles with no issue.

Reset
REQ-027 SHALL, while reset_n_in=0, clear both FIFOs, in-flight flags and credits immediately (asynchronously).
REQ-028 SHALL hold during reset: read_resp_valid_out=0, evict_valid_out=0, data outputs 0, both ready outputs 0, ram enables 0.
REQ-029 SHALL drop any in-flight operation when reset asserts mid-operation; no valid appears after reset release for it.
REQ-030 SHALL raise both request ready outputs in the first cycle after reset_n_in deasserts.

Verification
REQ-031 Write addr 5 data 0xA5, next cycle read addr 5 -> evict_data_out = prior content, read_resp_data_out=0xA5 one cycle after read issue.
REQ-032 Same-cycle read and write addr 9 (old 0x11, new 0x22) -> read_resp_data_out=0x11, evict_data_out=0x11; later read of 9 returns 0x22.
REQ-033 read_resp_ready_in=0, three back-to-back reads -> two accepted, read_req_ready_out low from third cycle; data stable; release ready -> two responses in order.
REQ-034 Reads to addr 0..63 streamed with ready high -> 64 responses, one per cycle, latency 1, no bubbles.
REQ-035 Assert reset_n_in one cycle after write issue -> evict_valid_out never asserts; ready outputs 1 after release.
REQ-036 Write-only stream with evict_ready_in toggling 1/0 -> every evicted entry delivered once, in order, credit count never above 2.

Source files
------------

// File: rtl/blockram_access_ctrl.sv
// Request/response front end for a synchronous block RAM: issues reads and writes,
// and returns read data and evicted (pre-write) entries through 2-deep credited FIFOs.

module blockram_access_ctrl_fifo #(
    parameter int W = 64
) (
    input  logic         clk_in,
    input  logic         reset_n_in,
    input  logic         issue_in,
    input  logic [W-1:0] entry_in,
    output logic         valid_out,
    output logic [W-1:0] data_out,
    input  logic         ready_in,
    output logic [1:0]   credits_out
);
    logic [1:0][W-1:0] slot;
    logic [1:0]        count;
    logic              inflight;
    logic              pop;
    logic              pop_fifo;
    logic              push;
    logic              push_slot;

    assign credits_out = count + {1'b0, inflight};
    assign valid_out   = (count != 2'd0) || inflight;
    // An in-flight entry is visible straight from the RAM when nothing older is queued.
    assign data_out    = (count != 2'd0) ? slot[0] : (inflight ? entry_in : '0);
    assign pop         = valid_out && ready_in;
    assign pop_fifo    = pop && (count != 2'd0);
    assign push        = inflight && !(pop && count == 2'd0);
    // With an entry in flight, count is at most 1, so one bit selects the tail slot.
    assign push_slot   = count[0] && !pop_fifo;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            slot     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue_in;
            if (pop_fifo)
                slot[0] <= slot[1];
            if (push)
                slot[push_slot] <= entry_in;
            count <= count + {1'b0, push} - {1'b0, pop_fifo};
        end
    end
endmodule

module blockram_access_ctrl #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUMBER_SET                = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = 6
) (
    input  logic                                 clk_in,
    input  logic                                 reset_n_in,
    input  logic                                 read_req_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_req_addr_in,
    output logic                                 read_req_ready_out,
    input  logic                                 write_req_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_req_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_req_data_in,
    output logic                                 write_req_ready_out,
    output logic                                 read_resp_valid_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_resp_data_out,
    input  logic                                 read_resp_ready_in,
    output logic                                 evict_valid_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] evict_data_out,
    input  logic                                 evict_ready_in,
    output logic                                 ram_read_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_read_set_addr_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in,
    output logic                                 ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_write_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_evict_entry_in
);
    localparam int W = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int A = SET_PTR_WIDTH_IN_BITS;

    if (NUMBER_SET > (1 << A)) begin : g_cfg_check
        $error("NUMBER_SET does not fit in SET_PTR_WIDTH_IN_BITS");
    end

    logic [1:0] rd_credits;
    logic [1:0] wr_credits;
    logic       rd_fire;
    logic       wr_fire;

    // Ready is held low through reset so nothing issues until credits are known clean.
    assign read_req_ready_out  = reset_n_in && (rd_credits < 2'd2);
    assign write_req_ready_out = reset_n_in && (wr_credits < 2'd2);
    assign rd_fire             = read_req_valid_in && read_req_ready_out;
    assign wr_fire             = write_req_valid_in && write_req_ready_out;

    // The RAM only performs a write when its read port is enabled too.
    always_comb begin
        ram_read_en_out        = rd_fire || wr_fire;
        ram_read_set_addr_out  = '0;
        ram_write_en_out       = wr_fire;
        ram_write_set_addr_out = '0;
        ram_write_entry_out    = '0;
        if (rd_fire)
            ram_read_set_addr_out = read_req_addr_in;
        else if (wr_fire)
            ram_read_set_addr_out = write_req_addr_in;
        if (wr_fire) begin
            ram_write_set_addr_out = write_req_addr_in;
            ram_write_entry_out    = write_req_data_in;
        end
    end

    blockram_access_ctrl_fifo #(.W(W)) u_rd_fifo (
        .clk_in      (clk_in),
        .reset_n_in  (reset_n_in),
        .issue_in    (rd_fire),
        .entry_in    (ram_read_entry_in),
        .valid_out   (read_resp_valid_out),
        .data_out    (read_resp_data_out),
        .ready_in    (read_resp_ready_in),
        .credits_out (rd_credits)
    );

    blockram_access_ctrl_fifo #(.W(W)) u_ev_fifo (
        .clk_in      (clk_in),
        .reset_n_in  (reset_n_in),
        .issue_in    (wr_fire),
        .entry_in    (ram_evict_entry_in),
        .valid_out   (evict_valid_out),
        .data_out    (evict_data_out),
        .ready_in    (evict_ready_in),
        .credits_out (wr_credits)
    );
endmodule
